// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU multiply scheduler:
// special-case flag codes, FSM states and operand classification.
package fpu_pkg;

   localparam logic [1:0] FLG_INF  = 2'b00;
   localparam logic [1:0] FLG_INV  = 2'b01;
   localparam logic [1:0] FLG_ZERO = 2'b10;
   localparam logic [1:0] FLG_NORM = 2'b11;

   localparam logic [7:0] EXP_MAX = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLASS,
      S_EXEC,
      S_WAIT,
      S_PACK,
      S_RESP
   } state_t;

   // Denormals have exp==0 and are folded into Zero.
   function automatic logic [1:0] class_code(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic a_nan, a_inf, a_zero;
      logic b_nan, b_inf, b_zero;
      logic [1:0] code;
      a_nan  = (a[30:23] == EXP_MAX) && (a[22:0] != 23'd0);
      a_inf  = (a[30:23] == EXP_MAX) && (a[22:0] == 23'd0);
      a_zero = (a[30:23] == 8'h00);
      b_nan  = (b[30:23] == EXP_MAX) && (b[22:0] != 23'd0);
      b_inf  = (b[30:23] == EXP_MAX) && (b[22:0] == 23'd0);
      b_zero = (b[30:23] == 8'h00);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         code = FLG_INV;
      else if (a_inf || b_inf)
         code = FLG_INF;
      else if (a_zero || b_zero)
         code = FLG_ZERO;
      else
         code = FLG_NORM;
      return code;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer
// moves to the other port only when a grant is accepted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       gidx
);

   logic ptr;

   // Lone request wins; on a tie the pointer picks the port.
   always_comb begin
      grant = 2'b00;
      if (req == 2'b11)
         grant = ptr ? 2'b10 : 2'b01;
      else
         grant = req;
   end

   assign gidx = grant[1];

   // Favour the port that did not win the last accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ptr <= 1'b0;
      else if (accept)
         ptr <= ~gidx;
   end

endmodule

// File: rtl/fpu_mul_sched.sv
// Issue scheduler sharing one multi-cycle FPU multiplier
// and its pack stage between two requesters.
module fpu_mul_sched
   import fpu_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   output logic [1:0]  req_ready,
   output logic        core_start,
   output logic [31:0] core_a,
   output logic [31:0] core_b,
   input  logic        core_done,
   output logic [1:0]  pk_flag,
   output logic        pk_s,
   input  logic [31:0] pk_c,
   input  logic        pk_ok,
   output logic [1:0]  resp_valid,
   output logic [31:0] resp_c,
   output logic        resp_flag,
   input  logic [1:0]  resp_ready
);

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [1:0]       grant;
   logic             gidx;
   logic             gsel;
   logic             accept;
   logic             abort;
   logic [CNT_W-1:0] wdog;
   logic [1:0]       code;

   assign accept = (state == S_IDLE) && (|req_valid);
   assign code   = class_code(core_a, core_b);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req_valid),
      .accept (accept),
      .grant  (grant),
      .gidx   (gidx)
   );

   // Job sequencing: accept, classify, run core or bypass, pack, respond.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         req_ready  <= 2'b00;
         core_start <= 1'b0;
         core_a     <= '0;
         core_b     <= '0;
         pk_flag    <= FLG_INV;
         pk_s       <= 1'b0;
         resp_valid <= 2'b00;
         resp_c     <= '0;
         resp_flag  <= 1'b0;
         gsel       <= 1'b0;
         abort      <= 1'b0;
         wdog       <= '0;
      end else begin
         req_ready  <= 2'b00;
         core_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  req_ready <= grant;
                  gsel      <= gidx;
                  core_a    <= gidx ? req_a1 : req_a0;
                  core_b    <= gidx ? req_b1 : req_b0;
                  abort     <= 1'b0;
                  state     <= S_CLASS;
               end
            end
            S_CLASS: begin
               pk_flag <= code;
               pk_s    <= core_a[31] ^ core_b[31];
               if (code == FLG_NORM) begin
                  core_start <= 1'b1;
                  state      <= S_EXEC;
               end else begin
                  state <= S_PACK;
               end
            end
            S_EXEC: begin
               wdog  <= '0;
               abort <= 1'b0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  state <= S_PACK;
               end else if (wdog == WD_LAST) begin
                  abort <= 1'b1;
                  state <= S_PACK;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_PACK: begin
               resp_c     <= abort ? 32'd0 : pk_c;
               resp_flag  <= ~abort & pk_ok;
               resp_valid <= gsel ? 2'b10 : 2'b01;
               state      <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready[gsel]) begin
                  resp_valid <= 2'b00;
                  resp_c     <= '0;
                  resp_flag  <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mul_sched.sv
// Directed self-checking bench for fpu_mul_sched:
// latency, classification, arbitration, timeout, hold, reset.
module tb_fpu_mul_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [31:0] req_a0 = '0, req_b0 = '0;
   logic [31:0] req_a1 = '0, req_b1 = '0;
   logic [1:0]  req_ready;
   logic        core_start;
   logic [31:0] core_a, core_b;
   logic        core_done = 1'b0;
   logic [1:0]  pk_flag;
   logic        pk_s;
   logic [31:0] pk_c = '0;
   logic        pk_ok = 1'b0;
   logic [1:0]  resp_valid;
   logic [31:0] resp_c;
   logic        resp_flag;
   logic [1:0]  resp_ready = 2'b00;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   int t0, t_core, t_resp;
   logic [1:0] gseq [4];

   fpu_mul_sched #(.TIMEOUT(64), .CNT_W(7)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a0     (req_a0),
      .req_b0     (req_b0),
      .req_a1     (req_a1),
      .req_b1     (req_b1),
      .req_ready  (req_ready),
      .core_start (core_start),
      .core_a     (core_a),
      .core_b     (core_b),
      .core_done  (core_done),
      .pk_flag    (pk_flag),
      .pk_s       (pk_s),
      .pk_c       (pk_c),
      .pk_ok      (pk_ok),
      .resp_valid (resp_valid),
      .resp_c     (resp_c),
      .resp_flag  (resp_flag),
      .resp_ready (resp_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request; core_done k cycles after core_start (k<=0: never).
   task automatic do_job(input int port, input logic [31:0] a,
                         input logic [31:0] b, input int k);
      int done_at;
      @(negedge clk);
      t0 = cyc;
      t_core = -1;
      t_resp = -1;
      done_at = -1;
      resp_ready = 2'b00;
      if (port == 0) begin
         req_a0 = a;
         req_b0 = b;
      end else begin
         req_a1 = a;
         req_b1 = b;
      end
      req_valid[port] = 1'b1;
      for (int n = 0; n < 200 && t_resp < 0; n++) begin
         @(negedge clk);
         if (req_ready[port]) req_valid[port] = 1'b0;
         if (core_start && t_core < 0) begin
            t_core = cyc;
            if (k > 0) done_at = cyc + k;
         end
         core_done = (cyc == done_at);
         if (resp_valid[port]) t_resp = cyc;
      end
      core_done = 1'b0;
      req_valid[port] = 1'b0;
      chk("resp_seen", 32'(t_resp >= 0), 32'd1);
   endtask

   // Hold resp_ready low for some cycles, then hand-shake.
   task automatic finish_resp(input int port, input int hold);
      logic [31:0] c0;
      c0 = resp_c;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid[port]), 32'd1);
         chk("hold_c", resp_c, c0);
         chk("hold_rdy", 32'(req_ready), 32'd0);
      end
      req_valid = 2'b00;
      resp_ready = 2'b00;
      resp_ready[port] = 1'b1;
      @(negedge clk);
      resp_ready = 2'b00;
      chk("resp_clr", 32'(resp_valid), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int ng;
      int seen;
      @(negedge clk);
      @(negedge clk);
      chk("rst_rdy", 32'(req_ready), 32'd0);
      chk("rst_start", 32'(core_start), 32'd0);
      chk("rst_a", core_a, 32'd0);
      chk("rst_b", core_b, 32'd0);
      chk("rst_flag", 32'(pk_flag), 32'd1);
      chk("rst_s", 32'(pk_s), 32'd0);
      chk("rst_rv", 32'(resp_valid), 32'd0);
      chk("rst_rc", resp_c, 32'd0);
      chk("rst_rf", 32'(resp_flag), 32'd0);
      rst = 1'b1;

      // 1.0 x 2.0 through the core, done after 3 cycles
      pk_c = 32'h4000_0000;
      pk_ok = 1'b1;
      do_job(0, 32'h3F80_0000, 32'h4000_0000, 3);
      chk("n_start_lat", 32'(t_core - t0), 32'd2);
      chk("n_resp_lat", 32'(t_resp - t0), 32'd7);
      chk("n_c", resp_c, 32'h4000_0000);
      chk("n_f", 32'(resp_flag), 32'd1);
      chk("n_code", 32'(pk_flag), 32'd3);
      chk("n_core_a", core_a, 32'h3F80_0000);
      finish_resp(0, 0);

      // Inf x 0 on port 1: invalid, bypass
      pk_c = 32'h7FC0_0000;
      do_job(1, 32'h7F80_0000, 32'h0000_0000, 0);
      chk("inv_nostart", 32'(t_core), 32'hFFFF_FFFF);
      chk("inv_lat", 32'(t_resp - t0), 32'd3);
      chk("inv_code", 32'(pk_flag), 32'd1);
      chk("inv_c", resp_c, 32'h7FC0_0000);
      finish_resp(1, 0);

      // Inf x 1.0: infinity code
      pk_c = 32'h7F80_0000;
      do_job(1, 32'h7F80_0000, 32'h3F80_0000, 0);
      chk("inf_code", 32'(pk_flag), 32'd0);
      chk("inf_lat", 32'(t_resp - t0), 32'd3);
      finish_resp(1, 0);

      // NaN x 0: invalid
      do_job(0, 32'h7FC0_0000, 32'h0000_0000, 0);
      chk("nan_code", 32'(pk_flag), 32'd1);
      finish_resp(0, 0);

      // -0 x 1.0: signed zero, response held 5 cycles
      pk_c = 32'h8000_0000;
      do_job(0, 32'h8000_0000, 32'h3F80_0000, 0);
      chk("z_code", 32'(pk_flag), 32'd2);
      chk("z_sign", 32'(pk_s), 32'd1);
      chk("z_nostart", 32'(t_core), 32'hFFFF_FFFF);
      chk("z_c", resp_c, 32'h8000_0000);
      req_valid[1] = 1'b1;
      resp_ready[1] = 1'b1;
      finish_resp(0, 5);

      // Watchdog abort, then a stray core_done in RESP
      pk_c = 32'h1234_5678;
      do_job(0, 32'h3F80_0000, 32'h3F80_0000, 0);
      chk("to_lat", 32'(t_resp - t0), 32'd68);
      chk("to_c", resp_c, 32'd0);
      chk("to_f", 32'(resp_flag), 32'd0);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      chk("to_stray_v", 32'(resp_valid), 32'd1);
      chk("to_stray_c", resp_c, 32'd0);
      finish_resp(0, 0);

      // Round-robin with both ports always requesting
      do_reset();
      req_a0 = '0; req_b0 = '0;
      req_a1 = '0; req_b1 = '0;
      req_valid = 2'b11;
      ng = 0;
      for (int n = 0; n < 100 && ng < 4; n++) begin
         @(negedge clk);
         resp_ready = resp_valid;
         if (req_ready != 2'b00) begin
            gseq[ng] = req_ready;
            ng++;
         end
      end
      req_valid = 2'b00;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         resp_ready = resp_valid;
      end
      resp_ready = 2'b00;
      chk("rr_cnt", 32'(ng), 32'd4);
      chk("rr_g0", 32'(gseq[0]), 32'd1);
      chk("rr_g1", 32'(gseq[1]), 32'd2);
      chk("rr_g2", 32'(gseq[2]), 32'd1);
      chk("rr_g3", 32'(gseq[3]), 32'd2);

      // Reset while waiting on the core
      @(negedge clk);
      req_a0 = 32'h4040_0000;
      req_b0 = 32'h4040_0000;
      req_valid[0] = 1'b1;
      seen = 0;
      for (int n = 0; n < 20 && seen == 0; n++) begin
         @(negedge clk);
         if (req_ready[0]) req_valid[0] = 1'b0;
         if (core_start) seen = 1;
      end
      req_valid = 2'b00;
      chk("wr_start", 32'(seen), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("wr_pre_a", core_a, 32'h4040_0000);
      rst = 1'b0;
      #1;
      chk("wr_a", core_a, 32'd0);
      chk("wr_b", core_b, 32'd0);
      chk("wr_flag", 32'(pk_flag), 32'd1);
      chk("wr_rv", 32'(resp_valid), 32'd0);
      chk("wr_rdy", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         core_done = (n == 1);
         if (resp_valid != 2'b00) seen = 1;
      end
      core_done = 1'b0;
      chk("wr_drop", 32'(seen), 32'd0);

      // Recovery: +0 x 2.0 on port 1
      pk_c = 32'h0000_0000;
      do_job(1, 32'h0000_0000, 32'h4000_0000, 0);
      chk("rc_code", 32'(pk_flag), 32'd2);
      chk("rc_sign", 32'(pk_s), 32'd0);
      chk("rc_lat", 32'(t_resp - t0), 32'd3);
      chk("rc_rv", 32'(resp_valid), 32'd2);
      finish_resp(1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fpu_mul_sched.md
# fpu_mul_sched

Issue scheduler that shares one multi-cycle FPU multiplier core and its result-packing stage between two requesters. It arbitrates round-robin and classifies IEEE-754 single-precision operands into the two-bit special-case code the packing stage consumes. Normal operands go through the core; special cases bypass it. The packed word is returned to the winning requester over a valid/ready handshake. It sits between the requester ports and the unpack/multiply/pack datapath.

## Interface
- `TIMEOUT`, 64: max cycles to wait for `core_done` before abort (≥2).
- `CNT_W`, 7: watchdog counter width; must hold `TIMEOUT`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester operation request.
- `req_a0`, `req_b0` in 32: operands, requester 0.
- `req_a1`, `req_b1` in 32: operands, requester 1.
- `req_ready` out 2: one-hot accept pulse.
- `core_start` out 1: single-cycle start to the multiplier core.
- `core_a`, `core_b` out 32: operands to the core, held from accept until the job ends.
- `core_done` in 1: core finished; `e`/`m`/`oom` are valid at the pack stage.
- `pk_flag` out 2: special-case code to the pack stage.
- `pk_s` out 1: result sign to the pack stage (`a[31]^b[31]`).
- `pk_c` in 32: packed word from the pack stage (combinational).
- `pk_ok` in 1: pack-stage valid flag.
- `resp_valid` out 2: per-requester result valid.
- `resp_c` out 32: result word.
- `resp_flag` out 1: captured `pk_ok`, 0 on abort.
- `resp_ready` in 2: per-requester result accept.

## Operation
- **Classification** (a, b): exp==FF and mant!=0 is NaN; exp==FF and mant==0 is Inf; exp==00 is Zero (denormals treated as zero).
  - Code 01 (invalid): NaN on either operand, or Inf×Zero.
  - Code 00 (infinity): else, either operand Inf.
  - Code 10 (signed zero): else, either operand Zero.
  - Code 11 (normal): otherwise.
- **Arbitration**: sub-module rr_arb2.
  - Only one request pending: it wins.
  - Both pending: the port not granted last wins.
  - Priority pointer updates only on accept. Reset pointer favours port 0.
- **FSM states**: IDLE, CLASS, EXEC, WAIT, PACK, RESP.
  - IDLE: any `req_valid` → pulse `req_ready[g]`, latch operands and grant index → CLASS.
  - CLASS: register code and sign. Code 11 → EXEC, else → PACK.
  - EXEC: `core_start`=1 for this cycle only, clear watchdog → WAIT.
  - WAIT: `core_done` → PACK. Watchdog reaching `TIMEOUT`-1 without `core_done` → PACK with abort set.
  - PACK: capture `pk_c`/`pk_ok` into response registers, or `resp_c`=0 and `resp_flag`=0 on abort → RESP.
  - RESP: `resp_valid[g]`=1. Hold `resp_c`/`resp_flag` stable until `resp_ready[g]`, then clear and → IDLE.
- `core_done` outside WAIT is ignored.
- `resp_ready` on the non-granted port is ignored.
- New requests are not accepted while a job is in flight (single outstanding).
- `pk_flag`/`pk_s` are driven from the registered code/sign from CLASS through PACK.

## Timing
- Reset values: `req_ready`=00, `core_start`=0, `core_a`/`core_b`=0, `pk_flag`=01, `pk_s`=0, `resp_valid`=00, `resp_c`=0, `resp_flag`=0, FSM=IDLE, pointer=port 0.
- Special-case latency: accept at T, `resp_valid` at T+3.
- Normal latency:
  - accept at T, `core_start` at T+2.
  - `core_done` at T+2+k (k≥1) gives `resp_valid` at T+4+k.
- Abort: `resp_valid` at T+4+`TIMEOUT`, with `resp_flag`=0.
- Earliest next accept is the cycle after the `resp_ready` handshake.
- `rst` asserted mid-job: all state returns to reset values immediately. Any in-flight response is dropped.

## Structure
- Package fpu_pkg holds:
  - flag codes FLG_INF=00, FLG_INV=01, FLG_ZERO=10, FLG_NORM=11;
  - EXP_MAX=8'hFF;
  - the FSM state enum;
  - the classification function.
- One sub-module: rr_arb2 (2-way round-robin, pointer register, grant-on-accept update).

## Test plan
- Port 0 sends 0x3F800000 × 0x40000000; core returns done after 3 cycles, pack gives 0x40000000/ok=1 → `resp_valid[0]` at T+7, `resp_c`=0x40000000, `resp_flag`=1.
- Port 1 sends 0x7F800000 × 0x00000000 → no `core_start`, `pk_flag`=01, `resp_valid[1]` at T+3.
- Port 0 sends 0x80000000 × 0x3F800000 → `pk_flag`=10, `pk_s`=1, core bypassed.
- Both ports request continuously with responses taken immediately → grants alternate 0,1,0,1; no starvation.
- `core_done` withheld with `TIMEOUT`=64 → `resp_c`=0 and `resp_flag`=0 at T+68; a pulse of `core_done` arriving in RESP is ignored.
- `resp_ready` held low 5 cycles → `resp_c` stable and `req_ready` stays 00; `rst` low while in WAIT → all outputs return to reset values at once.
